// File: rtl/store_queue.sv
// In-order circular store queue: dispatch allocation, execute capture, ROB commit and flush,
// one-at-a-time memory drain and registered store-to-load forwarding.
module store_queue #(
   parameter  int SUPER = 2,
   parameter  int SQ_SZ = 8,
   parameter  int AW    = 32,
   parameter  int DW    = 32,
   localparam int IW    = $clog2(SQ_SZ)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SUPER-1:0]    alloc_valid,
   output logic [SUPER*IW-1:0] alloc_idx,
   output logic                alloc_stall,
   input  logic [SUPER-1:0]    exe_valid,
   input  logic [SUPER*IW-1:0] exe_idx,
   input  logic [SUPER*AW-1:0] exe_addr,
   input  logic [SUPER*DW-1:0] exe_data,
   input  logic [SUPER-1:0]    commit_valid,
   input  logic [SUPER*IW-1:0] commit_idx,
   input  logic                inv_valid,
   input  logic [IW-1:0]       inv_idx,
   output logic                mem_wr_valid,
   output logic [AW-1:0]       mem_wr_addr,
   output logic [DW-1:0]       mem_wr_data,
   input  logic                mem_wr_ready,
   input  logic                ld_valid,
   input  logic [AW-1:0]       ld_addr,
   input  logic [IW-1:0]       ld_sq_idx,
   output logic                fwd_valid,
   output logic                fwd_hit,
   output logic [DW-1:0]       fwd_data,
   output logic                fwd_stall,
   output logic                commit_err
);
   localparam logic [IW:0]   SZ_PTR    = (IW+1)'(SQ_SZ);
   localparam logic [IW:0]   PTR_ONE   = (IW+1)'(1);
   localparam logic [AW-1:0] WORD_MASK = ~(AW'(3));

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} drain_state_t;

   // Pointers carry a wrap bit above the entry index.
   logic [IW:0]      r_head, r_cmt, r_tail;
   logic [SQ_SZ-1:0] r_vld, r_res, r_cmtd;
   logic [AW-1:0]    r_addr [SQ_SZ];
   logic [DW-1:0]    r_data [SQ_SZ];
   drain_state_t     r_state, w_state_nxt;
   logic             r_mem_wr_valid, r_fwd_valid, r_fwd_hit, r_fwd_stall, r_commit_err;
   logic [AW-1:0]    r_mem_wr_addr;
   logic [DW-1:0]    r_mem_wr_data, r_fwd_data;

   logic [IW:0]      w_used, w_free, w_n_alloc, w_cmt_nxt, w_inv_ptr, w_kill_n;
   logic [SUPER*IW-1:0] w_alloc_idx;
   logic [SQ_SZ-1:0] w_alloc_set, w_cmt_set, w_kill;
   logic             w_alloc_stall, w_alloc_go, w_cmt_bad, w_inv_ok, w_flush, w_inv_bad;
   logic             w_drain_load, w_drain_done, w_fwd_hit, w_fwd_stall;
   logic [IW-1:0]    w_ld_range, w_j;
   logic [DW-1:0]    w_fwd_data;

   // Free space comes from registered pointers only; a same-cycle drain does not help.
   always_comb begin
      w_used      = r_tail - r_head;
      w_free      = SZ_PTR - w_used;
      w_n_alloc   = '0;
      w_alloc_idx = '0;
      for (int i = 0; i < SUPER; i++) begin
         w_alloc_idx[i*IW +: IW] = r_tail[IW-1:0] + w_n_alloc[IW-1:0];
         w_n_alloc = w_n_alloc + {{IW{1'b0}}, alloc_valid[i]};
      end
      w_alloc_stall = inv_valid || (w_n_alloc > w_free);
      w_alloc_go    = (|alloc_valid) && !w_alloc_stall;
      w_alloc_set   = '0;
      for (int i = 0; i < SUPER; i++)
         if (w_alloc_go && alloc_valid[i]) w_alloc_set[w_alloc_idx[i*IW +: IW]] = 1'b1;
   end

   // Commit lanes in order; the first mismatching lane blocks itself and every younger lane.
   always_comb begin
      w_cmt_nxt = r_cmt;
      w_cmt_set = '0;
      w_cmt_bad = 1'b0;
      for (int i = 0; i < SUPER; i++) begin
         if (commit_valid[i] && !w_cmt_bad) begin
            if (commit_idx[i*IW +: IW] == w_cmt_nxt[IW-1:0] && w_cmt_nxt != r_tail) begin
               w_cmt_set[w_cmt_nxt[IW-1:0]] = 1'b1;
               w_cmt_nxt = w_cmt_nxt + PTR_ONE;
            end else begin
               w_cmt_bad = 1'b1;
            end
         end
      end
   end

   // Flush target is rebuilt with a wrap bit so that it sits at or after the post-commit cmt.
   always_comb begin
      w_inv_ptr = {w_cmt_nxt[IW] ^ (inv_idx < w_cmt_nxt[IW-1:0]), inv_idx};
      w_inv_ok  = (w_inv_ptr - w_cmt_nxt) <= (r_tail - w_cmt_nxt);
      w_flush   = inv_valid && w_inv_ok;
      w_inv_bad = inv_valid && !w_inv_ok;
      w_kill_n  = r_tail - w_inv_ptr;
      w_kill    = '0;
      for (int j = 0; j < SQ_SZ; j++)
         w_kill[j] = w_flush && ({1'b0, IW'(j) - inv_idx} < w_kill_n);
   end

   // Drain handshake: a write is accepted on a cycle where mem_wr_valid && mem_wr_ready;
   // while valid is high and ready is low, address and data stay unchanged.
   always_comb begin
      w_state_nxt  = r_state;
      w_drain_load = 1'b0;
      w_drain_done = 1'b0;
      case (r_state)
         S_IDLE: if (r_head != r_cmt && r_res[r_head[IW-1:0]] && r_cmtd[r_head[IW-1:0]]) begin
            w_drain_load = 1'b1;
            w_state_nxt  = S_BUSY;
         end
         S_BUSY: if (r_mem_wr_valid && mem_wr_ready) begin
            w_drain_done = 1'b1;
            w_state_nxt  = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Walk oldest to youngest so the last match seen is the youngest older store.
   always_comb begin
      w_ld_range  = ld_sq_idx - r_head[IW-1:0];
      w_fwd_hit   = 1'b0;
      w_fwd_stall = 1'b0;
      w_fwd_data  = '0;
      w_j         = '0;
      for (int k = 0; k < SQ_SZ; k++) begin
         w_j = r_head[IW-1:0] + IW'(k);
         if (IW'(k) < w_ld_range && r_vld[w_j]) begin
            if (!r_res[w_j]) begin
               w_fwd_stall = 1'b1;
            end else if (((r_addr[w_j] ^ ld_addr) & WORD_MASK) == '0) begin
               w_fwd_hit  = 1'b1;
               w_fwd_data = r_data[w_j];
            end
         end
      end
      if (w_fwd_stall) begin
         w_fwd_hit  = 1'b0;
         w_fwd_data = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head       <= '0;
         r_cmt        <= '0;
         r_tail       <= '0;
         r_vld        <= '0;
         r_res        <= '0;
         r_cmtd       <= '0;
         r_commit_err <= 1'b0;
      end else begin
         r_cmt <= w_cmt_nxt;
         if (w_flush)         r_tail <= w_inv_ptr;
         else if (w_alloc_go) r_tail <= r_tail + w_n_alloc;
         if (w_drain_done)    r_head <= r_head + PTR_ONE;
         if (w_cmt_bad || w_inv_bad) r_commit_err <= 1'b1;
         for (int j = 0; j < SQ_SZ; j++) begin
            if (w_drain_done && r_head[IW-1:0] == IW'(j)) begin
               r_vld[j]  <= 1'b0;
               r_res[j]  <= 1'b0;
               r_cmtd[j] <= 1'b0;
            end
            if (w_alloc_set[j]) begin
               r_vld[j]  <= 1'b1;
               r_res[j]  <= 1'b0;
               r_cmtd[j] <= 1'b0;
            end
            for (int i = 0; i < SUPER; i++)
               if (exe_valid[i] && exe_idx[i*IW +: IW] == IW'(j) && r_vld[j]) r_res[j] <= 1'b1;
            if (w_cmt_set[j]) r_cmtd[j] <= 1'b1;
            if (w_kill[j]) begin
               r_vld[j]  <= 1'b0;
               r_res[j]  <= 1'b0;
               r_cmtd[j] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int j = 0; j < SQ_SZ; j++)
         for (int i = 0; i < SUPER; i++)
            if (exe_valid[i] && exe_idx[i*IW +: IW] == IW'(j) && r_vld[j] && !w_kill[j]) begin
               r_addr[j] <= exe_addr[i*AW +: AW];
               r_data[j] <= exe_data[i*DW +: DW];
            end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_mem_wr_valid <= 1'b0;
         r_mem_wr_addr  <= '0;
         r_mem_wr_data  <= '0;
         r_fwd_valid    <= 1'b0;
         r_fwd_hit      <= 1'b0;
         r_fwd_stall    <= 1'b0;
         r_fwd_data     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_drain_load) begin
            r_mem_wr_valid <= 1'b1;
            r_mem_wr_addr  <= r_addr[r_head[IW-1:0]];
            r_mem_wr_data  <= r_data[r_head[IW-1:0]];
         end else if (w_drain_done) begin
            r_mem_wr_valid <= 1'b0;
         end
         r_fwd_valid <= ld_valid;
         r_fwd_hit   <= ld_valid && w_fwd_hit;
         r_fwd_stall <= ld_valid && w_fwd_stall;
         r_fwd_data  <= ld_valid ? w_fwd_data : '0;
      end
   end

   assign alloc_idx    = w_alloc_idx;
   assign alloc_stall  = w_alloc_stall;
   assign mem_wr_valid = r_mem_wr_valid;
   assign mem_wr_addr  = r_mem_wr_addr;
   assign mem_wr_data  = r_mem_wr_data;
   assign fwd_valid    = r_fwd_valid;
   assign fwd_hit      = r_fwd_hit;
   assign fwd_stall    = r_fwd_stall;
   assign fwd_data     = r_fwd_data;
   assign commit_err   = r_commit_err;
endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: direct checks on combinational outputs plus
// expected queues for drained writes and forwarding answers.
module tb_store_queue;
   localparam int SUPER = 2;
   localparam int SQ_SZ = 8;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int IW    = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic [SUPER-1:0]    alloc_valid;
   logic [SUPER*IW-1:0] alloc_idx;
   logic                alloc_stall;
   logic [SUPER-1:0]    exe_valid;
   logic [SUPER*IW-1:0] exe_idx;
   logic [SUPER*AW-1:0] exe_addr;
   logic [SUPER*DW-1:0] exe_data;
   logic [SUPER-1:0]    commit_valid;
   logic [SUPER*IW-1:0] commit_idx;
   logic                inv_valid;
   logic [IW-1:0]       inv_idx;
   logic                mem_wr_valid;
   logic [AW-1:0]       mem_wr_addr;
   logic [DW-1:0]       mem_wr_data;
   logic                mem_wr_ready;
   logic                ld_valid;
   logic [AW-1:0]       ld_addr;
   logic [IW-1:0]       ld_sq_idx;
   logic                fwd_valid;
   logic                fwd_hit;
   logic [DW-1:0]       fwd_data;
   logic                fwd_stall;
   logic                commit_err;

   store_queue #(.SUPER(SUPER), .SQ_SZ(SQ_SZ), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_idx(alloc_idx), .alloc_stall(alloc_stall),
      .exe_valid(exe_valid), .exe_idx(exe_idx), .exe_addr(exe_addr), .exe_data(exe_data),
      .commit_valid(commit_valid), .commit_idx(commit_idx),
      .inv_valid(inv_valid), .inv_idx(inv_idx),
      .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_wr_ready(mem_wr_ready),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_sq_idx(ld_sq_idx),
      .fwd_valid(fwd_valid), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
      .commit_err(commit_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [63:0] exp_mem_q[$];
   logic [33:0] exp_fwd_q[$];
   logic [63:0] e_mem;
   logic [33:0] e_fwd;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      alloc_valid  = '0;
      exe_valid    = '0;
      exe_idx      = '0;
      exe_addr     = '0;
      exe_data     = '0;
      commit_valid = '0;
      commit_idx   = '0;
      inv_valid    = 1'b0;
      inv_idx      = '0;
      ld_valid     = 1'b0;
      ld_addr      = '0;
      ld_sq_idx    = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      mem_wr_ready = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_mem_wr_valid", mem_wr_valid, 0);
      check("rst_mem_wr_addr", mem_wr_addr, 0);
      check("rst_mem_wr_data", mem_wr_data, 0);
      check("rst_fwd_valid", fwd_valid, 0);
      check("rst_fwd_hit", fwd_hit, 0);
      check("rst_fwd_stall", fwd_stall, 0);
      check("rst_fwd_data", fwd_data, 0);
      check("rst_commit_err", commit_err, 0);
      check("rst_alloc_stall", alloc_stall, 0);
   endtask

   task automatic drive_exe(input int lane, input logic [IW-1:0] idx,
                            input logic [AW-1:0] addr, input logic [DW-1:0] data);
      exe_valid[lane]          = 1'b1;
      exe_idx[lane*IW +: IW]   = idx;
      exe_addr[lane*AW +: AW]  = addr;
      exe_data[lane*DW +: DW]  = data;
   endtask

   task automatic drive_commit(input int lane, input logic [IW-1:0] idx);
      commit_valid[lane]         = 1'b1;
      commit_idx[lane*IW +: IW]  = idx;
   endtask

   task automatic drive_load(input logic [AW-1:0] addr, input logic [IW-1:0] sq_idx,
                             input logic stall, input logic hit, input logic [DW-1:0] data);
      ld_valid  = 1'b1;
      ld_addr   = addr;
      ld_sq_idx = sq_idx;
      exp_fwd_q.push_back({stall, hit, data});
   endtask

   // Scoreboard side: forwarding answers and accepted drain writes are popped as they appear.
   always @(negedge clk) begin
      if (!rst && fwd_valid) begin
         if (exp_fwd_q.size() == 0) begin
            check("fwd_unexpected", 1, 0);
         end else begin
            e_fwd = exp_fwd_q.pop_front();
            check("fwd_stall", fwd_stall, e_fwd[33]);
            check("fwd_hit", fwd_hit, e_fwd[32]);
            check("fwd_data", fwd_data, e_fwd[31:0]);
         end
      end
      if (!rst && mem_wr_valid && mem_wr_ready) begin
         if (exp_mem_q.size() == 0) begin
            check("mem_unexpected", 1, 0);
         end else begin
            e_mem = exp_mem_q.pop_front();
            check("mem_wr_addr", mem_wr_addr, e_mem[63:32]);
            check("mem_wr_data", mem_wr_data, e_mem[31:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc;
      logic [AW-1:0] r_addr_m [4];
      logic [DW-1:0] r_data_m [4];
      logic [AW-1:0] la;
      int            sq;
      logic          m_hit;
      logic [DW-1:0] m_data;

      // Fill the queue two at a time until it is full.
      do_reset();
      for (int c = 0; c < 4; c++) begin
         alloc_valid = 2'b11;
         #1;
         check("fill_stall", alloc_stall, 0);
         check("fill_idx0", alloc_idx[IW-1:0], 2*c);
         check("fill_idx1", alloc_idx[2*IW-1:IW], 2*c+1);
         tick();
      end
      alloc_valid = 2'b11;
      #1;
      check("full_stall2", alloc_stall, 1);
      tick();
      alloc_valid = 2'b01;
      #1;
      check("full_stall1", alloc_stall, 1);
      check("full_tail_idx", alloc_idx[IW-1:0], 0);
      alloc_valid = 2'b00;
      #1;
      check("full_stall0", alloc_stall, 0);
      clear_inputs();

      // Drain held under backpressure, then a second drain after head advances.
      do_reset();
      alloc_valid = 2'b11;
      tick();
      clear_inputs();
      drive_exe(0, 3'd0, 32'h100, 32'hAA);
      drive_commit(0, 3'd0);
      exp_mem_q.push_back({32'h100, 32'hAA});
      tick();
      clear_inputs();
      cyc = 0;
      while (!mem_wr_valid && cyc < 10) begin
         tick();
         cyc++;
      end
      check("drain_start", mem_wr_valid, 1);
      for (int c = 0; c < 3; c++) begin
         check("hold_valid", mem_wr_valid, 1);
         check("hold_addr", mem_wr_addr, 32'h100);
         check("hold_data", mem_wr_data, 32'hAA);
         tick();
      end
      mem_wr_ready = 1'b1;
      tick();
      check("drain_release", mem_wr_valid, 0);
      check("drain1_popped", exp_mem_q.size(), 0);
      drive_exe(0, 3'd1, 32'h104, 32'hBB);
      drive_commit(0, 3'd1);
      exp_mem_q.push_back({32'h104, 32'hBB});
      tick();
      clear_inputs();
      cyc = 0;
      while (exp_mem_q.size() != 0 && cyc < 10) begin
         tick();
         cyc++;
      end
      check("drain2_done", exp_mem_q.size(), 0);
      mem_wr_ready = 1'b0;

      // Youngest older match wins; empty range and other address miss.
      do_reset();
      alloc_valid = 2'b11;
      tick();
      clear_inputs();
      drive_exe(0, 3'd0, 32'h40, 32'h11);
      drive_exe(1, 3'd1, 32'h40, 32'h22);
      tick();
      clear_inputs();
      drive_load(32'h42, 3'd2, 1'b0, 1'b1, 32'h22);
      tick();
      drive_load(32'h40, 3'd1, 1'b0, 1'b1, 32'h11);
      tick();
      drive_load(32'h40, 3'd0, 1'b0, 1'b0, 32'h0);
      tick();
      drive_load(32'h80, 3'd2, 1'b0, 1'b0, 32'h0);
      tick();
      clear_inputs();
      tick();
      tick();

      // Unresolved older store forces a stall.
      do_reset();
      alloc_valid = 2'b11;
      tick();
      clear_inputs();
      drive_exe(0, 3'd0, 32'h40, 32'h11);
      tick();
      clear_inputs();
      drive_load(32'h40, 3'd2, 1'b1, 1'b0, 32'h0);
      tick();
      drive_load(32'h40, 3'd1, 1'b0, 1'b1, 32'h11);
      tick();
      clear_inputs();
      tick();
      tick();

      // Flush with same-cycle commit, allocation and execute to a discarded entry.
      do_reset();
      for (int c = 0; c < 3; c++) begin
         alloc_valid = 2'b11;
         tick();
      end
      clear_inputs();
      drive_exe(0, 3'd0, 32'h10, 32'h01);
      drive_exe(1, 3'd1, 32'h14, 32'h02);
      tick();
      clear_inputs();
      drive_exe(0, 3'd2, 32'h18, 32'h03);
      drive_commit(0, 3'd0);
      drive_commit(1, 3'd1);
      tick();
      clear_inputs();
      inv_valid   = 1'b1;
      inv_idx     = 3'd3;
      alloc_valid = 2'b11;
      drive_commit(0, 3'd2);
      drive_exe(0, 3'd4, 32'h200, 32'h99);
      #1;
      check("flush_alloc_stall", alloc_stall, 1);
      tick();
      clear_inputs();
      check("flush_no_err", commit_err, 0);
      drive_load(32'h200, 3'd6, 1'b0, 1'b0, 32'h0);
      alloc_valid = 2'b11;
      #1;
      check("post_flush_stall", alloc_stall, 0);
      check("post_flush_idx0", alloc_idx[IW-1:0], 3);
      check("post_flush_idx1", alloc_idx[2*IW-1:IW], 4);
      tick();
      clear_inputs();
      alloc_valid = 2'b11;
      #1;
      check("refill_idx0", alloc_idx[IW-1:0], 5);
      tick();
      alloc_valid = 2'b11;
      #1;
      check("one_free_stall2", alloc_stall, 1);
      alloc_valid = 2'b01;
      #1;
      check("one_free_stall1", alloc_stall, 0);
      check("one_free_idx", alloc_idx[IW-1:0], 7);
      clear_inputs();
      tick();
      tick();

      // Commit mismatches: lane 1 error blocks, later wrong index leaves cmt unchanged.
      do_reset();
      for (int c = 0; c < 2; c++) begin
         alloc_valid = 2'b11;
         tick();
      end
      clear_inputs();
      drive_commit(0, 3'd0);
      drive_commit(1, 3'd5);
      tick();
      clear_inputs();
      check("cmt_err_lane1", commit_err, 1);
      drive_commit(0, 3'd1);
      tick();
      clear_inputs();
      drive_commit(0, 3'd4);
      tick();
      clear_inputs();
      check("cmt_err_sticky", commit_err, 1);
      mem_wr_ready = 1'b1;
      drive_exe(0, 3'd0, 32'h500, 32'hA0);
      drive_exe(1, 3'd1, 32'h504, 32'hA1);
      exp_mem_q.push_back({32'h500, 32'hA0});
      exp_mem_q.push_back({32'h504, 32'hA1});
      tick();
      clear_inputs();
      drive_exe(0, 3'd2, 32'h508, 32'hA2);
      drive_exe(1, 3'd3, 32'h50C, 32'hA3);
      tick();
      clear_inputs();
      for (int c = 0; c < 12; c++) tick();
      check("cmt_drains_done", exp_mem_q.size(), 0);
      check("cmt_no_extra_drain", mem_wr_valid, 0);
      check("cmt_err_held", commit_err, 1);
      mem_wr_ready = 1'b0;
      do_reset();

      // Random forwarding queries against a small reference of four resolved stores.
      for (int c = 0; c < 2; c++) begin
         alloc_valid = 2'b11;
         tick();
      end
      clear_inputs();
      for (int k = 0; k < 4; k++) begin
         r_addr_m[k] = 32'h1000 + 4 * $urandom_range(0, 2);
         r_data_m[k] = $urandom_range(1, 255);
      end
      drive_exe(0, 3'd0, r_addr_m[0], r_data_m[0]);
      drive_exe(1, 3'd1, r_addr_m[1], r_data_m[1]);
      tick();
      clear_inputs();
      drive_exe(0, 3'd2, r_addr_m[2], r_data_m[2]);
      drive_exe(1, 3'd3, r_addr_m[3], r_data_m[3]);
      tick();
      clear_inputs();
      for (int q = 0; q < 8; q++) begin
         la = 32'h1000 + 4 * $urandom_range(0, 2) + $urandom_range(0, 3);
         sq = $urandom_range(0, 4);
         m_hit  = 1'b0;
         m_data = '0;
         for (int k = 0; k < sq; k++)
            if (r_addr_m[k][AW-1:2] == la[AW-1:2]) begin
               m_hit  = 1'b1;
               m_data = r_data_m[k];
            end
         drive_load(la, IW'(sq), 1'b0, m_hit, m_data);
         tick();
      end
      clear_inputs();
      tick();
      tick();

      check("fwd_queue_empty", exp_fwd_q.size(), 0);
      check("mem_queue_empty", exp_mem_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
